surf_event_merge: RTL and testbench



---
 rtl/surf_event_merge_if.sv | 13 +
 rtl/surf_event_merge.sv | 145 ++++++++++++++
 tb/tb_surf_event_merge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/surf_event_merge_if.sv
// Byte-wide AXI-Stream bundle with LANES parallel lanes packed side by side.
// Lane i carries tdata[8i+7:8i] and bit i of each control vector.
interface surf_event_merge_if #(
    parameter int LANES = 1
);
    logic [8*LANES-1:0] tdata;
    logic [LANES-1:0]   tvalid;
    logic [LANES-1:0]   tlast;
    logic [LANES-1:0]   tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/surf_event_merge.sv
// Merges one packet from each SURF stream, in order 0..NSURF-1, into a single event.
// Also checks packet lengths, abandons stalled SURFs and counts completed events.
module surf_event_merge #(
    parameter int NSURF          = 7,
    parameter int NUM_BYTES      = 12292,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SEL_W         = (NSURF > 1) ? $clog2(NSURF) : 1,
    localparam int TO_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic               aclk,
    input  logic               rst,
    surf_event_merge_if.slave  s_dout,
    surf_event_merge_if.master m_ev,
    output logic [SEL_W-1:0]   surf_sel_o,
    output logic               busy_o,
    output logic [15:0]        event_count_o,
    output logic [NSURF-1:0]   len_err_o,
    output logic [NSURF-1:0]   timeout_err_o
);

    typedef enum logic [1:0] {IDLE, STREAM, FILL} state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [13:0]        byte_cnt_reg, byte_cnt_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic [15:0]        event_count_reg, event_count_next;
    logic [NSURF-1:0]   len_err_reg, len_err_next;
    logic [NSURF-1:0]   timeout_err_reg, timeout_err_next;

    logic [7:0]         lane_data [NSURF];
    logic               sel_valid;
    logic               sel_last;
    logic               last_sel;
    logic               beat;
    logic [14:0]        cnt_plus;

    generate
        for (genvar gi = 0; gi < NSURF; gi++) begin : g_lane
            assign lane_data[gi] = s_dout.tdata[8*gi +: 8];
            // Only the selected SURF ever sees ready, so unselected data stays upstream.
            assign s_dout.tready[gi] = (state_reg == STREAM) &&
                                       (sel_reg == SEL_W'(gi)) && m_ev.tready[0];
        end
    endgenerate

    assign sel_valid = s_dout.tvalid[sel_reg];
    assign sel_last  = s_dout.tlast[sel_reg];
    assign last_sel  = (sel_reg == SEL_W'(NSURF - 1));
    assign beat      = (state_reg == STREAM) && sel_valid && m_ev.tready[0];
    assign cnt_plus  = {1'b0, byte_cnt_reg} + 15'd1;

    always_comb begin
        state_next       = state_reg;
        sel_next         = sel_reg;
        byte_cnt_next    = byte_cnt_reg;
        to_cnt_next      = to_cnt_reg;
        event_count_next = event_count_reg;
        len_err_next     = len_err_reg;
        timeout_err_next = timeout_err_reg;
        m_ev.tdata       = 8'h00;
        m_ev.tvalid      = 1'b0;
        m_ev.tlast       = 1'b0;

        case (state_reg)
            IDLE: begin
                sel_next      = '0;
                byte_cnt_next = '0;
                to_cnt_next   = '0;
                if (s_dout.tvalid[0]) state_next = STREAM;
            end
            STREAM: begin
                m_ev.tdata  = lane_data[sel_reg];
                m_ev.tvalid = sel_valid;
                m_ev.tlast  = sel_last && last_sel;
                if (beat) begin
                    to_cnt_next = '0;
                    if (byte_cnt_reg != 14'h3FFF) byte_cnt_next = byte_cnt_reg + 14'd1;
                    if (sel_last) begin
                        // Length is only reported; tlast alone delimits the packet.
                        if (cnt_plus != 15'(NUM_BYTES)) len_err_next[sel_reg] = 1'b1;
                        byte_cnt_next = '0;
                        if (!last_sel) begin
                            sel_next = sel_reg + SEL_W'(1);
                        end else begin
                            event_count_next = event_count_reg + 16'd1;
                            sel_next         = '0;
                            state_next       = IDLE;
                        end
                    end
                end else if (!sel_valid) begin
                    // Backpressure (valid high, ready low) neither counts nor clears.
                    if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_next[sel_reg] = 1'b1;
                        to_cnt_next               = '0;
                        byte_cnt_next             = '0;
                        if (!last_sel) sel_next = sel_reg + SEL_W'(1);
                        else           state_next = FILL;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end
            end
            FILL: begin
                // A lost final SURF still needs an event terminator downstream.
                m_ev.tdata  = 8'h00;
                m_ev.tvalid = 1'b1;
                m_ev.tlast  = 1'b1;
                if (m_ev.tready[0]) begin
                    event_count_next = event_count_reg + 16'd1;
                    sel_next         = '0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            byte_cnt_reg    <= '0;
            to_cnt_reg      <= '0;
            event_count_reg <= '0;
            len_err_reg     <= '0;
            timeout_err_reg <= '0;
        end else begin
            state_reg       <= state_next;
            sel_reg         <= sel_next;
            byte_cnt_reg    <= byte_cnt_next;
            to_cnt_reg      <= to_cnt_next;
            event_count_reg <= event_count_next;
            len_err_reg     <= len_err_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign surf_sel_o    = sel_reg;
    assign busy_o        = (state_reg != IDLE);
    assign event_count_o = event_count_reg;
    assign len_err_o     = len_err_reg;
    assign timeout_err_o = timeout_err_reg;

endmodule

// File: tb/tb_surf_event_merge.sv
// Scoreboard bench for surf_event_merge: each event's bytes are queued in merge
// order as the SURF packets are set up, then popped as the merged stream emerges.
module tb_surf_event_merge;

    localparam int NS = 7;
    localparam int NB = 24;
    localparam int TO = 100;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    surf_event_merge_if #(.LANES(NS)) sif ();
    surf_event_merge_if #(.LANES(1))  mif ();

    logic [2:0]      surf_sel;
    logic            busy;
    logic [15:0]     ev_cnt;
    logic [NS-1:0]   len_err;
    logic [NS-1:0]   to_err;

    logic [8*NS-1:0] lane_data  = '0;
    logic [NS-1:0]   lane_valid = '0;
    logic [NS-1:0]   lane_last  = '0;
    logic            m_rdy      = 1'b0;

    assign sif.tdata  = lane_data;
    assign sif.tvalid = lane_valid;
    assign sif.tlast  = lane_last;
    assign mif.tready = m_rdy;

    surf_event_merge #(
        .NSURF(NS), .NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_dout        (sif),
        .m_ev          (mif),
        .surf_sel_o    (surf_sel),
        .busy_o        (busy),
        .event_count_o (ev_cnt),
        .len_err_o     (len_err),
        .timeout_err_o (to_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_q [$];       // {tlast, tdata}
    int len  [NS];               // packet length (tlast position) per SURF
    int send [NS];               // bytes actually offered before the SURF goes silent
    int dly  [NS];               // idle cycles after the previous SURF is done
    int pos  [NS];
    int sel_cycles [NS];
    int seed;
    int duty;

    function automatic logic [7:0] pat(input int k, input int j);
        return 8'(k * 37 + j * 11 + seed);
    endfunction

    task automatic setup(input int s);
        seed = s;
        for (int k = 0; k < NS; k++) begin
            len[k] = NB; send[k] = NB; dly[k] = 0; pos[k] = 0; sel_cycles[k] = 0;
        end
    endtask

    task automatic push_expected();
        exp_q.delete();
        for (int k = 0; k < NS; k++)
            for (int j = 0; j < send[k]; j++)
                exp_q.push_back({(k == NS-1) && (send[k] == len[k]) && (j == len[k]-1), pat(k, j)});
        if (send[NS-1] < len[NS-1]) exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic drive_lanes();
        for (int k = 0; k < NS; k++) begin
            if (dly[k] > 0 && (k == 0 || pos[k-1] >= send[k-1])) dly[k]--;
            lane_valid[k]       = (dly[k] == 0) && (pos[k] < send[k]);
            lane_data[8*k +: 8] = pat(k, pos[k]);
            lane_last[k]        = (pos[k] == len[k] - 1);
        end
        m_rdy = ($urandom_range(0, 99) < duty);
    endtask

    task automatic do_reset();
        rst = 1'b1; lane_valid = '0; lane_last = '0; m_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_sel"},   32'(surf_sel), 32'd0);
        check({tag, "_evcnt"}, 32'(ev_cnt), 32'd0);
        check({tag, "_lenerr"}, 32'(len_err), 32'd0);
        check({tag, "_toerr"}, 32'(to_err), 32'd0);
        check({tag, "_sready"}, 32'(sif.tready), 32'd0);
        check({tag, "_mvalid"}, 32'(mif.tvalid), 32'd0);
        check({tag, "_mlast"}, 32'(mif.tlast), 32'd0);
    endtask

    // Runs until the scoreboard drains, stop_after beats are seen, or the budget expires.
    task automatic run_event(input int max_cycles, input int stop_after);
        int cyc   = 0;
        int beats = 0;
        logic [8:0] e;
        drive_lanes();
        while (exp_q.size() > 0 && beats != stop_after && cyc < max_cycles) begin
            @(negedge aclk);
            check("rdy_onehot0", 32'($onehot0(sif.tready)), 32'd1);
            if (busy && surf_sel < NS) sel_cycles[surf_sel]++;
            if (mif.tvalid && m_rdy) begin
                e = exp_q.pop_front();
                check("data", 32'(mif.tdata), 32'(e[7:0]));
                check("last", 32'(mif.tlast), 32'(e[8]));
                beats++;
            end
            for (int k = 0; k < NS; k++)
                if (lane_valid[k] && sif.tready[k]) pos[k]++;
            @(posedge aclk);
            #1 drive_lanes();
            cyc++;
        end
        check("cycle_budget", 32'(cyc < max_cycles), 32'd1);
    endtask

    task automatic finish_event(input string name, input logic [15:0] exp_ev,
                                input logic [NS-1:0] exp_len, input logic [NS-1:0] exp_to);
        m_rdy = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("no_extra_beat", 32'(mif.tvalid), 32'd0);
            @(posedge aclk);
            #1;
        end
        check("busy_end", 32'(busy), 32'd0);
        check("sel_end", 32'(surf_sel), 32'd0);
        check("evcnt", 32'(ev_cnt), 32'(exp_ev));
        check("len_err", 32'(len_err), 32'(exp_len));
        check("to_err", 32'(to_err), 32'(exp_to));
        $display("event %s: events=%0d len_err=%b timeout_err=%b pending=%0d",
                 name, ev_cnt, len_err, to_err, exp_q.size());
    endtask

    initial begin
        duty = 100;
        setup(0);
        do_reset();
        check_reset_outputs("rst");

        // Clean event, full-rate downstream.
        setup(1); duty = 100; push_expected();
        run_event(2000, -1);
        finish_event("clean", 16'd1, '0, '0);

        // Same data under 30% ready and a late SURF3 that stays inside the timeout.
        do_reset();
        setup(1); dly[3] = 90; duty = 30; push_expected();
        run_event(4000, -1);
        finish_event("throttled", 16'd1, '0, '0);

        // Short SURF2 packet: flagged but forwarded whole.
        do_reset();
        setup(2); len[2] = NB - 2; send[2] = NB - 2; duty = 70; push_expected();
        run_event(3000, -1);
        finish_event("short_surf2", 16'd1, 7'b0000100, '0);

        // SURF4 never valid: skipped after exactly TO idle cycles.
        do_reset();
        setup(3); send[4] = 0; duty = 100; push_expected();
        run_event(3000, -1);
        check("sel4_cycles", 32'(sel_cycles[4]), 32'(TO));
        finish_event("timeout_surf4", 16'd1, '0, 7'b0010000);

        // SURF6 stalls after 10 bytes: FILL closes the event.
        do_reset();
        setup(4); send[6] = 10; duty = 100; push_expected();
        run_event(3000, -1);
        finish_event("timeout_surf6", 16'd1, '0, 7'b1000000);

        // Reset in the middle of SURF1, then a clean event.
        do_reset();
        setup(5); duty = 100; push_expected();
        run_event(2000, NB + 5);
        rst = 1'b1; lane_valid = '0; lane_last = '0;
        @(posedge aclk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        setup(6); push_expected();
        run_event(2000, -1);
        finish_event("after_reset", 16'd1, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
